lsu_mem_ctrl: RTL and testbench

//  Memory-stage load/store sequencer for the 5-stage RV32I pipeline.
//  - Consumes MemWrite/modeBU, decoded in D and piped to M, plus the ALU address.
//  - Runs a valid/ready transaction to data memory and drives byte strobes.
//  - Sign/zero-extends load data.
//  - Holds StallM high while an access is outstanding, so IF..M freeze.

---
 rtl/lsu_mem_ctrl_pkg.sv | 30 +++
 rtl/lsu_mem_ctrl_if.sv | 24 ++
 rtl/lsu_mem_ctrl_lane_align.sv | 58 +++++
 rtl/lsu_mem_ctrl.sv | 165 ++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared types and constants for the memory-stage load/store sequencer.
// Holds the access-size encodings, the FSM state type and the alignment rule.
package lsu_pkg;

    localparam logic [2:0] MODE_NONE = 3'b000;
    localparam logic [2:0] MODE_W    = 3'b001;
    localparam logic [2:0] MODE_H    = 3'b010;
    localparam logic [2:0] MODE_B    = 3'b011;
    localparam logic [2:0] MODE_HU   = 3'b100;
    localparam logic [2:0] MODE_BU   = 3'b101;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        DONE    = 2'd3
    } lsu_state_t;

    // Byte accesses are never misaligned; halves need a[0]=0, words a[1:0]=0.
    function automatic logic is_misaligned(input logic [2:0] mode, input logic [1:0] addr_lo);
        logic mis;
        case (mode)
            MODE_W:         mis = (addr_lo != 2'b00);
            MODE_H, MODE_HU: mis = addr_lo[0];
            default:        mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Valid/ready data-memory bus between the load/store sequencer and memory.
// master = sequencer side, slave = memory side.
interface lsu_mem_ctrl_if;

    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;

    modport master (
        output mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata, mem_rvalid
    );

    modport slave (
        input  mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata, mem_rvalid
    );

endinterface

// File: rtl/lsu_mem_ctrl_lane_align.sv
// Combinational byte-lane steering: store replication and strobes on the way out,
// load lane select with sign/zero extension on the way back.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  st_mode_i,
    input  logic [1:0]  st_addr_i,
    input  logic [31:0] st_data_i,
    output logic [31:0] st_wdata_o,
    output logic [3:0]  st_wstrb_o,
    input  logic [2:0]  ld_mode_i,
    input  logic [1:0]  ld_addr_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Store side: replicate the datum across every lane and enable only the addressed ones.
    always_comb begin
        st_wdata_o = st_data_i;
        st_wstrb_o = 4'b1111;
        case (st_mode_i)
            MODE_B, MODE_BU: begin
                st_wdata_o = {4{st_data_i[7:0]}};
                st_wstrb_o = 4'b0001 << st_addr_i;
            end
            MODE_H, MODE_HU: begin
                st_wdata_o = {2{st_data_i[15:0]}};
                st_wstrb_o = st_addr_i[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata_o = st_data_i;
                st_wstrb_o = 4'b1111;
            end
        endcase
    end

    // Load side: pick the addressed byte/half, then extend according to the mode.
    always_comb begin
        case (ld_addr_i)
            2'd0:    byte_s = ld_rdata_i[7:0];
            2'd1:    byte_s = ld_rdata_i[15:8];
            2'd2:    byte_s = ld_rdata_i[23:16];
            default: byte_s = ld_rdata_i[31:24];
        endcase
        half_s = ld_addr_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
        case (ld_mode_i)
            MODE_B:  ld_data_o = {{24{byte_s[7]}}, byte_s};
            MODE_BU: ld_data_o = {24'd0, byte_s};
            MODE_H:  ld_data_o = {{16{half_s[15]}}, half_s};
            MODE_HU: ld_data_o = {16'd0, half_s};
            default: ld_data_o = ld_rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Memory-stage load/store sequencer: runs one valid/ready access per M instruction,
// stalls IF..M while it is outstanding, and bounds the wait with a timeout.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  MemReadM,
    input  logic                  MemWriteM,
    input  logic [2:0]            modeBUM,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    output logic                  StallM,
    output logic [DATA_WIDTH-1:0] ReadDataM,
    output logic                  MisalignM,
    output logic                  BusErrM,
    lsu_mem_ctrl_if.master        mem
);

    localparam int CNT_W = 16;

    lsu_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [2:0]            mode_q, mode_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                  req_s;
    logic                  mis_s;
    logic                  start_s;
    logic                  tmo_s;
    logic [31:0]           st_wdata_s;
    logic [3:0]            st_wstrb_s;
    logic [31:0]           ld_data_s;

    lsu_lane_align u_lane_align (
        .st_mode_i  (modeBUM),
        .st_addr_i  (ALUResultM[1:0]),
        .st_data_i  (WriteDataM),
        .st_wdata_o (st_wdata_s),
        .st_wstrb_o (st_wstrb_s),
        .ld_mode_i  (mode_q),
        .ld_addr_i  (addr_q[1:0]),
        .ld_rdata_i (mem.mem_rdata),
        .ld_data_o  (ld_data_s)
    );

    // Request decode; gated by rst_n so every output reads 0 while reset is held.
    always_comb begin
        req_s   = rst_n && (MemReadM || MemWriteM) && (modeBUM != MODE_NONE);
        mis_s   = is_misaligned(modeBUM, ALUResultM[1:0]);
        start_s = req_s && !mis_s;
        tmo_s   = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
    end

    // Next-state and datapath updates of the access sequencer.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        mode_d  = mode_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start_s) begin
                    state_d = ISSUE;
                    addr_d  = ALUResultM;
                    we_d    = MemWriteM;
                    mode_d  = modeBUM;
                    wdata_d = st_wdata_s;
                    wstrb_d = MemWriteM ? st_wstrb_s : 4'b0000;
                    err_d   = 1'b0;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (mem.mem_ready && (we_q || mem.mem_rvalid)) begin
                    state_d = DONE;
                    rdata_d = we_q ? rdata_q : ld_data_s;
                end else if (tmo_s) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    rdata_d = {DATA_WIDTH{1'b0}};
                end else if (mem.mem_ready) begin
                    state_d = WAIT_RD;
                end else begin
                    state_d = ISSUE;
                end
            end
            WAIT_RD: begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (mem.mem_rvalid) begin
                    state_d = DONE;
                    rdata_d = ld_data_s;
                end else if (tmo_s) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    rdata_d = {DATA_WIDTH{1'b0}};
                end else begin
                    state_d = WAIT_RD;
                end
            end
            DONE: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and captured-access registers; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= {DATA_WIDTH{1'b0}};
            we_q    <= 1'b0;
            mode_q  <= MODE_NONE;
            wdata_q <= {DATA_WIDTH{1'b0}};
            wstrb_q <= 4'b0000;
            rdata_q <= {DATA_WIDTH{1'b0}};
            err_q   <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            mode_q  <= mode_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output drive: bus fields come straight from the captured registers.
    always_comb begin
        StallM        = (state_q == IDLE && start_s) || (state_q == ISSUE) || (state_q == WAIT_RD);
        MisalignM     = (state_q == IDLE) && req_s && mis_s;
        BusErrM       = (state_q == DONE) && err_q;
        ReadDataM     = rdata_q;
        mem.mem_valid = (state_q == ISSUE);
        mem.mem_we    = we_q;
        mem.mem_addr  = {addr_q[31:2], 2'b00};
        mem.mem_wdata = wdata_q;
        mem.mem_wstrb = wstrb_q;
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed self-checking bench for lsu_mem_ctrl with hand-computed expectations.
module tb_lsu_mem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        MemReadM;
    logic        MemWriteM;
    logic [2:0]  modeBUM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic        StallM;
    logic [31:0] ReadDataM;
    logic        MisalignM;
    logic        BusErrM;

    int n_assert = 0;
    int n_fail   = 0;

    lsu_mem_ctrl_if mem_if ();

    lsu_mem_ctrl #(.DATA_WIDTH(32), .TIMEOUT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .modeBUM    (modeBUM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .StallM     (StallM),
        .ReadDataM  (ReadDataM),
        .MisalignM  (MisalignM),
        .BusErrM    (BusErrM),
        .mem        (mem_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        MemReadM   = 1'b0;
        MemWriteM  = 1'b0;
        modeBUM    = 3'b000;
        ALUResultM = 32'h0000_0000;
        WriteDataM = 32'h0000_0000;
    endtask

    // Load with ready+rvalid on the first ISSUE cycle; ends sitting in DONE.
    task automatic do_load(input logic [2:0] mode, input logic [31:0] addr, input logic [31:0] rdata,
                           output logic [31:0] iss_addr, output logic [3:0] iss_wstrb, output logic iss_we,
                           output logic [31:0] done_data, output logic done_stall);
        MemReadM = 1'b1; modeBUM = mode; ALUResultM = addr;
        tick();
        iss_addr = mem_if.mem_addr; iss_wstrb = mem_if.mem_wstrb; iss_we = mem_if.mem_we;
        mem_if.mem_ready = 1'b1; mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = rdata;
        tick();
        mem_if.mem_ready = 1'b0; mem_if.mem_rvalid = 1'b0;
        idle_inputs();
        #1;
        done_data = ReadDataM; done_stall = StallM;
    endtask

    // Store accepted on the first ISSUE cycle; ends sitting in DONE.
    task automatic do_store(input logic [2:0] mode, input logic [31:0] addr, input logic [31:0] data,
                            output logic [31:0] iss_addr, output logic [3:0] iss_wstrb,
                            output logic [31:0] iss_wdata, output logic iss_we);
        MemWriteM = 1'b1; modeBUM = mode; ALUResultM = addr; WriteDataM = data;
        tick();
        iss_addr = mem_if.mem_addr; iss_wstrb = mem_if.mem_wstrb;
        iss_wdata = mem_if.mem_wdata; iss_we = mem_if.mem_we;
        mem_if.mem_ready = 1'b1;
        tick();
        mem_if.mem_ready = 1'b0;
        idle_inputs();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; idle_inputs();
        mem_if.mem_ready = 1'b0; mem_if.mem_rvalid = 1'b0; mem_if.mem_rdata = 32'h0000_0000;
        repeat (2) tick();
        n_assert++;
        if ({StallM, MisalignM, BusErrM, mem_if.mem_valid, mem_if.mem_we} !== 5'b00000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 00000",
                {StallM, MisalignM, BusErrM, mem_if.mem_valid, mem_if.mem_we});
        end
        n_assert++;
        if ({ReadDataM, mem_if.mem_addr, mem_if.mem_wdata, mem_if.mem_wstrb} !== 100'd0) begin
            n_fail++; $display("FAIL reset_data: rd=%h addr=%h wd=%h strb=%b expected all 0",
                ReadDataM, mem_if.mem_addr, mem_if.mem_wdata, mem_if.mem_wstrb);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_sw();
        int stalls = 0;
        MemWriteM = 1'b1; modeBUM = 3'b001; ALUResultM = 32'h0000_0104; WriteDataM = 32'hDEAD_BEEF;
        #1;
        stalls += int'(StallM);
        n_assert++;
        if (StallM !== 1'b1 || mem_if.mem_valid !== 1'b0) begin
            n_fail++; $display("FAIL sw_start: stall=%b valid=%b expected 1 0", StallM, mem_if.mem_valid);
        end
        tick();
        stalls += int'(StallM);
        n_assert++;
        if (mem_if.mem_valid !== 1'b1 || mem_if.mem_we !== 1'b1) begin
            n_fail++; $display("FAIL sw_issue_ctrl: valid=%b we=%b expected 1 1", mem_if.mem_valid, mem_if.mem_we);
        end
        n_assert++;
        if (mem_if.mem_addr !== 32'h0000_0104 || mem_if.mem_wstrb !== 4'b1111 || mem_if.mem_wdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL sw_issue_bus: addr=%h strb=%b wd=%h expected 00000104 1111 deadbeef",
                mem_if.mem_addr, mem_if.mem_wstrb, mem_if.mem_wdata);
        end
        tick();
        stalls += int'(StallM);
        n_assert++;
        if (mem_if.mem_valid !== 1'b1) begin
            n_fail++; $display("FAIL sw_hold_valid: got %b expected 1", mem_if.mem_valid);
        end
        mem_if.mem_ready = 1'b1;
        tick();
        mem_if.mem_ready = 1'b0;
        stalls += int'(StallM);
        n_assert++;
        if (StallM !== 1'b0 || mem_if.mem_valid !== 1'b0) begin
            n_fail++; $display("FAIL sw_done: stall=%b valid=%b expected 0 0", StallM, mem_if.mem_valid);
        end
        idle_inputs();
        tick();
        stalls += int'(StallM);
        n_assert++;
        if (stalls != 3) begin
            n_fail++; $display("FAIL sw_stall_cycles: got %0d expected 3", stalls);
        end
    endtask

    task automatic test_lb_lbu();
        logic [31:0] a; logic [3:0] s; logic we; logic [31:0] d; logic st;
        do_load(3'b011, 32'h0000_0203, 32'h80FF_1234, a, s, we, d, st);
        n_assert++;
        if (a !== 32'h0000_0200 || s !== 4'b0000 || we !== 1'b0) begin
            n_fail++; $display("FAIL lb_issue: addr=%h strb=%b we=%b expected 00000200 0000 0", a, s, we);
        end
        n_assert++;
        if (d !== 32'hFFFF_FF80 || st !== 1'b0) begin
            n_fail++; $display("FAIL lb_data: got %h stall=%b expected ffffff80 0", d, st);
        end
        tick();
        do_load(3'b101, 32'h0000_0203, 32'h80FF_1234, a, s, we, d, st);
        n_assert++;
        if (d !== 32'h0000_0080) begin
            n_fail++; $display("FAIL lbu_data: got %h expected 00000080", d);
        end
        tick();
    endtask

    task automatic test_sh();
        logic [31:0] a; logic [3:0] s; logic [31:0] wd; logic we;
        do_store(3'b010, 32'h0000_000A, 32'h0000_ABCD, a, s, wd, we);
        n_assert++;
        if (a !== 32'h0000_0008 || s !== 4'b1100 || wd !== 32'hABCD_ABCD || we !== 1'b1) begin
            n_fail++; $display("FAIL sh_issue: addr=%h strb=%b wd=%h we=%b expected 00000008 1100 abcdabcd 1",
                a, s, wd, we);
        end
        tick();
    endtask

    task automatic test_lh();
        logic [31:0] a; logic [3:0] s; logic we; logic [31:0] d; logic st;
        do_load(3'b010, 32'h0000_000A, 32'h8001_0000, a, s, we, d, st);
        n_assert++;
        if (d !== 32'hFFFF_8001) begin
            n_fail++; $display("FAIL lh_data: got %h expected ffff8001", d);
        end
        tick();
    endtask

    task automatic test_misalign();
        int valid_seen = 0;
        MemReadM = 1'b1; modeBUM = 3'b001; ALUResultM = 32'h0000_0006;
        #1;
        valid_seen += int'(mem_if.mem_valid);
        n_assert++;
        if (MisalignM !== 1'b1 || StallM !== 1'b0) begin
            n_fail++; $display("FAIL misalign_pulse: mis=%b stall=%b expected 1 0", MisalignM, StallM);
        end
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            tick();
            valid_seen += int'(mem_if.mem_valid);
        end
        n_assert++;
        if (valid_seen != 0 || MisalignM !== 1'b0 || ReadDataM !== 32'hFFFF_8001) begin
            n_fail++; $display("FAIL misalign_quiet: valid_cycles=%0d mis=%b rd=%h expected 0 0 ffff8001",
                valid_seen, MisalignM, ReadDataM);
        end
    endtask

    task automatic test_timeout();
        MemReadM = 1'b1; modeBUM = 3'b001; ALUResultM = 32'h0000_0100;
        tick();
        n_assert++;
        if (mem_if.mem_valid !== 1'b1 || BusErrM !== 1'b0) begin
            n_fail++; $display("FAIL tmo_issue: valid=%b err=%b expected 1 0", mem_if.mem_valid, BusErrM);
        end
        mem_if.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_assert++;
            if (StallM !== 1'b1 || BusErrM !== 1'b0 || mem_if.mem_valid !== 1'b0) begin
                n_fail++; $display("FAIL tmo_wait%0d: stall=%b err=%b valid=%b expected 1 0 0",
                    i, StallM, BusErrM, mem_if.mem_valid);
            end
        end
        tick();
        n_assert++;
        if (BusErrM !== 1'b1 || ReadDataM !== 32'h0000_0000 || StallM !== 1'b0 || mem_if.mem_valid !== 1'b0) begin
            n_fail++; $display("FAIL tmo_done: err=%b rd=%h stall=%b valid=%b expected 1 00000000 0 0",
                BusErrM, ReadDataM, StallM, mem_if.mem_valid);
        end
        mem_if.mem_ready = 1'b0;
        mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 32'h1234_5678;
        idle_inputs();
        tick();
        mem_if.mem_rvalid = 1'b0;
        n_assert++;
        if (BusErrM !== 1'b0 || ReadDataM !== 32'h0000_0000) begin
            n_fail++; $display("FAIL tmo_late_rvalid: err=%b rd=%h expected 0 00000000", BusErrM, ReadDataM);
        end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] a; logic [3:0] s; logic [31:0] wd; logic we;
        MemReadM = 1'b1; modeBUM = 3'b001; ALUResultM = 32'h0000_0300;
        tick();
        mem_if.mem_ready = 1'b1;
        tick();
        n_assert++;
        if (StallM !== 1'b1 || mem_if.mem_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_wait: stall=%b valid=%b expected 1 0", StallM, mem_if.mem_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_assert++;
        if (StallM !== 1'b0 || mem_if.mem_valid !== 1'b0 || ReadDataM !== 32'h0000_0000 || mem_if.mem_addr !== 32'h0000_0000) begin
            n_fail++; $display("FAIL rstmid_async: stall=%b valid=%b rd=%h addr=%h expected 0 0 00000000 00000000",
                StallM, mem_if.mem_valid, ReadDataM, mem_if.mem_addr);
        end
        mem_if.mem_ready = 1'b0;
        idle_inputs();
        tick();
        rst_n = 1'b1;
        tick();
        do_store(3'b011, 32'h0000_0011, 32'h0000_005A, a, s, wd, we);
        n_assert++;
        if (a !== 32'h0000_0010 || s !== 4'b0010 || wd !== 32'h5A5A_5A5A) begin
            n_fail++; $display("FAIL sb_after_rst: addr=%h strb=%b wd=%h expected 00000010 0010 5a5a5a5a", a, s, wd);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_sw();
        test_lb_lbu();
        test_sh();
        test_timeout();
        test_lh();
        test_misalign();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
